syscall_controller: RTL

- Sequences syscall service for the MIPS core; sits between the ID/EX syscall detect and the board display/halt logic.
- Accepts one syscall request at a time and decodes service code v0.
- Latches a0 into the display register, stalls the pipeline for a programmable dwell, and enters a sticky halted state on exit.
- Flags unsupported codes without stalling.

---
 rtl/syscall_controller_pkg.sv | 25 ++
 rtl/syscall_controller_dwell_timer.sv | 36 +++
 rtl/syscall_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/syscall_controller_pkg.sv
// syscall_pkg: shared definitions for the syscall controller.
//   - MIPS service-code constants (v0 values)
//   - FSM state encoding
//   - is_display_code(): true for services that latch a0 into the display
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

    localparam int DWELL_CNT_W = 8;  // enough for DWELL_CYCLES up to 255

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        HALTED = 2'd2
    } sys_state_e;

    function automatic logic is_display_code(input logic [31:0] code);
        return (code == SYS_PRINT_INT) || (code == SYS_PRINT_HEX) ||
               (code == SYS_PRINT_CHAR);
    endfunction

endpackage

// File: rtl/syscall_controller_dwell_timer.sv
// dwell_timer: down-counter timing the display stall.
// Ports:
//   clk, rst      clock, async active-high reset (counter -> 0)
//   load          load load_value this cycle (takes priority over enable)
//   load_value    count to load
//   enable        decrement while nonzero; holds at 0 (never wraps)
//   zero          counter currently 0
module dwell_timer
    import syscall_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DWELL_CNT_W-1:0] load_value,
    input  logic                   enable,
    output logic                   zero
);

    logic [DWELL_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_value;
        else if (enable && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/syscall_controller.sv
// syscall_controller: sequences syscall service between EX syscall detect
// and the board display/halt logic.
// Ports:
//   clk, rst        clock, async active-high reset
//   req, v0, a0     syscall valid in EX, service code, argument
//   stall           freeze PC/pipeline (combinational)
//   ack             one-cycle retire pulse (combinational)
//   halt            sticky exit indication
//   hex, hex_valid  display register and "a display service completed"
//   bad_code        sticky unsupported-code flag
// Optional build macro SYSCALL_STATS_EN adds syscall_count and stall_cycles.
module syscall_controller
    import syscall_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,   // 1..255
    parameter int HALT_CODE    = 10,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              ack,
    output logic              halt,
    output logic [DATA_W-1:0] hex,
    output logic              hex_valid,
    output logic              bad_code
`ifdef SYSCALL_STATS_EN
    ,
    output logic [31:0]       syscall_count,
    output logic [31:0]       stall_cycles
`endif
);

    sys_state_e        state_q, state_d;
    logic              halt_q, halt_d;
    logic [DATA_W-1:0] hex_q, hex_d;
    logic              hex_valid_q, hex_valid_d;
    logic              bad_code_q, bad_code_d;

    logic              tmr_load, tmr_enable, tmr_zero;
    logic              enter_halt;
    logic [31:0]       code;

    assign code = 32'(v0);

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (DWELL_CNT_W'(DWELL_CYCLES - 1)),
        .enable     (tmr_enable),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        hex_d       = hex_q;
        hex_valid_d = hex_valid_q;
        bad_code_d  = bad_code_q;
        tmr_load    = 1'b0;
        tmr_enable  = 1'b0;
        enter_halt  = 1'b0;
        stall       = 1'b0;
        ack         = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                if (is_display_code(code)) begin
                    // Freeze in the request cycle itself.
                    stall    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = DWELL;
                    if (code == SYS_PRINT_CHAR) begin
                        hex_d      = '0;
                        hex_d[7:0] = a0[7:0];
                    end else begin
                        hex_d = a0;
                    end
                end else if (code == 32'(HALT_CODE)) begin
                    stall      = 1'b1;
                    halt_d     = 1'b1;
                    enter_halt = 1'b1;
                    state_d    = HALTED;
                end else begin
                    // Unsupported: retire immediately, no stall.
                    ack        = 1'b1;
                    bad_code_d = 1'b1;
                end
            end
            DWELL: begin
                // stall stays high through the ack cycle; the pipeline
                // advances on ack regardless.
                stall      = 1'b1;
                tmr_enable = 1'b1;
                if (tmr_zero) begin
                    ack         = 1'b1;
                    hex_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            HALTED:  stall = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            halt_q      <= 1'b0;
            hex_q       <= '0;
            hex_valid_q <= 1'b0;
            bad_code_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            hex_q       <= hex_d;
            hex_valid_q <= hex_valid_d;
            bad_code_q  <= bad_code_d;
        end
    end

    assign halt      = halt_q;
    assign hex       = hex_q;
    assign hex_valid = hex_valid_q;
    assign bad_code  = bad_code_q;

`ifdef SYSCALL_STATS_EN
    logic [31:0] syscall_count_q, syscall_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        syscall_count_d = syscall_count_q;
        stall_cycles_d  = stall_cycles_q;
        if (ack || enter_halt)
            syscall_count_d = syscall_count_q + 32'd1;
        if (stall && (state_q != HALTED))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syscall_count_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            syscall_count_q <= syscall_count_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign syscall_count = syscall_count_q;
    assign stall_cycles  = stall_cycles_q;
`endif

endmodule
